// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: requester handshake bus plus SRAM port of the shared-SRAM arbiter.
// The lock vector exists only when ARB_LOCK_EN is defined.
interface sram_port_arbiter_if #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 18
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]         rdata;
  logic                          sram_en;
  logic                          sram_we;
  logic [ADDR_WIDTH-1:0]         sram_addr;
  logic [DATA_WIDTH-1:0]         sram_wdata;
  logic [DATA_WIDTH-1:0]         sram_rdata;
`ifdef ARB_LOCK_EN
  logic [NUM_REQ-1:0]            lock;

  // Arbiter view: requesters in, SRAM out.
  modport slave (
    input  req, we, addr, wdata, lock, sram_rdata,
    output gnt, rvalid, rdata, sram_en, sram_we, sram_addr, sram_wdata
  );

  // Environment view: requesters and the SRAM macro.
  modport master (
    output req, we, addr, wdata, lock, sram_rdata,
    input  gnt, rvalid, rdata, sram_en, sram_we, sram_addr, sram_wdata
  );
`else
  // Arbiter view: requesters in, SRAM out.
  modport slave (
    input  req, we, addr, wdata, sram_rdata,
    output gnt, rvalid, rdata, sram_en, sram_we, sram_addr, sram_wdata
  );

  // Environment view: requesters and the SRAM macro.
  modport master (
    output req, we, addr, wdata, sram_rdata,
    input  gnt, rvalid, rdata, sram_en, sram_we, sram_addr, sram_wdata
  );
`endif
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin sharing of one single-port synchronous SRAM among NUM_REQ
// requesters. One access per two cycles; read data returns two cycles after the SRAM access
// with a one-hot rvalid. Define ARB_LOCK_EN to add the lock input (burst ownership).
module sram_port_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 18
) (
  input  logic               clk,
  input  logic               reset_n,
  sram_port_arbiter_if.slave bus
);
  localparam int unsigned      IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned      CAND_W   = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  localparam logic [0:0] S_ARB   = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
  logic [NUM_REQ-1:0]    rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  sram_en_q, sram_en_d;
  logic                  sram_we_q, sram_we_d;
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0] sram_wdata_q, sram_wdata_d;

  logic [IDX_W-1:0]      win;
  logic                  win_vld;
  logic [CAND_W-1:0]     cand;
  logic [NUM_REQ-1:0]    win_oh;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
`ifdef ARB_LOCK_EN
  logic                  own_q, own_d;
  logic                  sel_lock;
`endif

  // Winner: first requester after the last grant, wrapping; a locked owner keeps the port.
  always_comb begin
    win     = LAST_RST;
    win_vld = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_q} + CAND_W'(i);
      if (cand >= CAND_W'(NUM_REQ)) begin
        cand = cand - CAND_W'(NUM_REQ);
      end
      if (!win_vld && bus.req[cand[IDX_W-1:0]]) begin
        win     = cand[IDX_W-1:0];
        win_vld = 1'b1;
      end
    end
`ifdef ARB_LOCK_EN
    if (own_q && bus.req[last_q] && bus.lock[last_q]) begin
      win     = last_q;
      win_vld = 1'b1;
    end
`endif
  end

  // Select the winner's command fields.
  always_comb begin
    win_oh    = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
`ifdef ARB_LOCK_EN
    sel_lock  = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == IDX_W'(i)) begin
        win_oh[i] = 1'b1;
        sel_we    = bus.we[i];
        sel_addr  = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef ARB_LOCK_EN
        sel_lock  = bus.lock[i];
`endif
      end
    end
  end

  // Next state, SRAM command and read-return pipeline.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = '0;
    sram_en_d    = 1'b0;
    sram_we_d    = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    rd_pend_d    = (sram_en_q && !sram_we_q) ? gnt_q : '0;
    rvalid_d     = rd_pend_q;
    rdata_d      = (|rd_pend_q) ? bus.sram_rdata : rdata_q;
`ifdef ARB_LOCK_EN
    own_d        = own_q;
`endif
    case (state_q)
      S_ARB: begin
`ifdef ARB_LOCK_EN
        if (!bus.req[last_q]) begin
          own_d = 1'b0;
        end
`endif
        if (win_vld) begin
          gnt_d        = win_oh;
          sram_en_d    = 1'b1;
          sram_we_d    = sel_we;
          sram_addr_d  = sel_addr;
          sram_wdata_d = sel_wdata;
          last_d       = win;
          state_d      = S_ISSUE;
`ifdef ARB_LOCK_EN
          own_d        = sel_lock;
`endif
        end
      end
      S_ISSUE: state_d = S_ARB;
      default: state_d = S_ARB;
    endcase
  end

  // State and output registers; synchronous reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_ARB;
      last_q       <= LAST_RST;
      gnt_q        <= '0;
      rvalid_q     <= '0;
      rd_pend_q    <= '0;
      rdata_q      <= '0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
`ifdef ARB_LOCK_EN
      own_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      rvalid_q     <= rvalid_d;
      rd_pend_q    <= rd_pend_d;
      rdata_q      <= rdata_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
`ifdef ARB_LOCK_EN
      own_q        <= own_d;
`endif
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.rvalid     = rvalid_q;
  assign bus.rdata      = rdata_q;
  assign bus.sram_en    = sram_en_q;
  assign bus.sram_we    = sram_we_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed scenarios plus random traffic against a cycle-level
// reference model of the arbiter, with a behavioural SRAM attached to the DUT.
module tb_sram_port_arbiter;
  localparam int unsigned N  = 3;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 18;

  typedef struct {
    int            cyc;
    int            id;
    logic [DW-1:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic reset_n;

  sram_port_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Power-up SRAM contents for locations never written.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 11'h012) return 18'h2A5C3;
    return DW'(a) * 18'd613 + 18'h155;
  endfunction

  // Behavioural SRAM: one-cycle registered read.
  logic [DW-1:0] mem    [2**AW];
  bit            mem_wr [2**AW];
  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_we) begin
        mem[bus.sram_addr]    <= bus.sram_wdata;
        mem_wr[bus.sram_addr] <= 1'b1;
      end else begin
        bus.sram_rdata <= mem_wr[bus.sram_addr] ? mem[bus.sram_addr] : init_val(bus.sram_addr);
      end
    end
  end

  // Reference model state.
  logic [DW-1:0] emem [2**AW];
  bit            ewr  [2**AW];
  logic [N-1:0]  exp_gnt, exp_rvalid;
  logic [DW-1:0] exp_rdata, exp_wdata;
  logic          exp_en, exp_we;
  logic [AW-1:0] exp_addr;
  int            last_id;
  bit            own;
  rd_t           rd_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int base     = 0;
  int glog_id[$];
  int glog_cyc[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_gnt    = '0;
    exp_rvalid = '0;
    exp_rdata  = '0;
    exp_wdata  = '0;
    exp_en     = 1'b0;
    exp_we     = 1'b0;
    exp_addr   = '0;
    last_id    = N - 1;
    own        = 1'b0;
    rd_q.delete();
  endtask

  // Advance to the next cycle and compare every output with the model.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("gnt",        bus.gnt,        exp_gnt);
    chk("rvalid",     bus.rvalid,     exp_rvalid);
    chk("rdata",      bus.rdata,      exp_rdata);
    chk("sram_en",    bus.sram_en,    exp_en);
    chk("sram_we",    bus.sram_we,    exp_we);
    chk("sram_addr",  bus.sram_addr,  exp_addr);
    chk("sram_wdata", bus.sram_wdata, exp_wdata);
    for (int i = 0; i < N; i++) begin
      if (bus.gnt[i]) begin
        glog_id.push_back(i);
        glog_cyc.push_back(cyc - base);
      end
    end
  endtask

  // Apply this cycle's inputs and predict the outputs of the following cycle.
  task automatic drive(input logic rn, input logic [N-1:0] rq, input logic [N-1:0] wv,
                       input logic [N*AW-1:0] av, input logic [N*DW-1:0] dv,
                       input logic [N-1:0] lk_in);
    logic [N-1:0] ng, nrv, lk;
    int w;
    lk = lk_in;
`ifndef ARB_LOCK_EN
    lk = '0;
`endif
    reset_n   = rn;
    bus.req   = rq;
    bus.we    = wv;
    bus.addr  = av;
    bus.wdata = dv;
`ifdef ARB_LOCK_EN
    bus.lock  = lk;
`endif
    if (!rn) begin
      model_reset();
      return;
    end
    nrv = '0;
    if (rd_q.size() > 0 && rd_q[0].cyc == cyc + 1) begin
      nrv[rd_q[0].id] = 1'b1;
      exp_rdata = rd_q[0].data;
      void'(rd_q.pop_front());
    end
    ng = '0;
    w  = -1;
    // Arbitration only happens in a cycle without a grant showing.
    if (exp_gnt == '0) begin
      if (!rq[last_id]) own = 1'b0;
      if (own && rq[last_id] && lk[last_id]) begin
        w = last_id;
      end else begin
        for (int i = 1; i <= N; i++) begin
          int c;
          c = (last_id + i) % N;
          if (w < 0 && rq[c]) w = c;
        end
      end
    end
    if (w >= 0) begin
      ng[w]     = 1'b1;
      exp_en    = 1'b1;
      exp_we    = wv[w];
      exp_addr  = av[w*AW +: AW];
      exp_wdata = dv[w*DW +: DW];
      last_id   = w;
      own       = lk[w];
      if (wv[w]) begin
        emem[exp_addr] = exp_wdata;
        ewr[exp_addr]  = 1'b1;
      end else begin
        rd_q.push_back('{cyc: cyc + 3, id: w,
                         data: (ewr[exp_addr] ? emem[exp_addr] : init_val(exp_addr))});
      end
    end else begin
      exp_en = 1'b0;
      exp_we = 1'b0;
    end
    exp_gnt    = ng;
    exp_rvalid = nrv;
  endtask

  task automatic step(input logic rn, input logic [N-1:0] rq, input logic [N-1:0] wv,
                      input logic [N*AW-1:0] av, input logic [N*DW-1:0] dv,
                      input logic [N-1:0] lk);
    tick();
    drive(rn, rq, wv, av, dv, lk);
  endtask

  task automatic step_idle();
    step(1'b1, '0, '0, '0, '0, '0);
  endtask

  // One requester asking for one access.
  task automatic req1(input int id, input logic wbit, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    logic [N-1:0]    rq, wv;
    logic [N*AW-1:0] av;
    logic [N*DW-1:0] dv;
    rq = '0; wv = '0; av = '0; dv = '0;
    rq[id] = 1'b1;
    wv[id] = wbit;
    av[id*AW +: AW] = a;
    dv[id*DW +: DW] = d;
    step(1'b1, rq, wv, av, dv, '0);
  endtask

  logic [N*AW-1:0] av_c;
  logic [N-1:0]    pend, pwe, lkv;
  logic [N*AW-1:0] pav;
  logic [N*DW-1:0] pdv;
  logic            rn;

  initial begin
    reset_n   = 1'b0;
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
`ifdef ARB_LOCK_EN
    bus.lock  = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) av_c[i*AW +: AW] = AW'(11'h100 + i);

    // Reset state
    step(1'b0, '0, '0, '0, '0, '0);

    // Single read from requester 0
    req1(0, 1'b0, 11'h012, '0);
    step_idle();
    chk("single_gnt",  bus.gnt,       3'b001);
    chk("single_en",   bus.sram_en,   1'b1);
    chk("single_we",   bus.sram_we,   1'b0);
    chk("single_addr", bus.sram_addr, 11'h012);
    step_idle();
    step_idle();
    chk("single_rvalid", bus.rvalid, 3'b001);
    chk("single_rdata",  bus.rdata,  18'h2A5C3);

    // Write then read by requester 1
    req1(1, 1'b1, 11'h020, 18'h3FFFF);
    step_idle();
    chk("wr_gnt", bus.gnt,     3'b010);
    chk("wr_we",  bus.sram_we, 1'b1);
    req1(1, 1'b0, 11'h020, '0);
    step_idle();
    chk("wr_no_rvalid", bus.rvalid,  3'b000);
    chk("rd_we",        bus.sram_we, 1'b0);
    step_idle();
    step_idle();
    chk("rd_rvalid", bus.rvalid, 3'b010);
    chk("rd_rdata",  bus.rdata,  18'h3FFFF);

    // All three requesting continuously after reset
    step(1'b0, '0, '0, '0, '0, '0);
    base = cyc + 1;
    glog_id.delete();
    glog_cyc.delete();
    for (int k = 0; k < 12; k++) step(1'b1, 3'b111, '0, av_c, '0, '0);
    chk("rr_count", glog_id.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < glog_id.size()) begin
        chk("rr_id",  glog_id[i],  i % 3);
        chk("rr_cyc", glog_cyc[i], 2 * i + 1);
      end
    end

    // Pointer wrap: last=2, req=101
    glog_id.delete();
    glog_cyc.delete();
    for (int k = 0; k < 4; k++) step(1'b1, 3'b101, '0, av_c, '0, '0);
    chk("wrap_count", glog_id.size(), 2);
    if (glog_id.size() >= 2) begin
      chk("wrap_first",  glog_id[0], 0);
      chk("wrap_second", glog_id[1], 2);
    end
    repeat (4) step_idle();

    // Reset in the cycle after a read grant
    req1(0, 1'b0, 11'h012, '0);
    step_idle();
    step(1'b0, '0, '0, '0, '0, '0);
    step_idle();
    chk("rst_gnt",    bus.gnt,        3'b000);
    chk("rst_rvalid", bus.rvalid,     3'b000);
    chk("rst_rdata",  bus.rdata,      18'h0);
    chk("rst_en",     bus.sram_en,    1'b0);
    chk("rst_addr",   bus.sram_addr,  11'h0);
    chk("rst_wdata",  bus.sram_wdata, 18'h0);
    step_idle();
    chk("rst_no_rvalid", bus.rvalid, 3'b000);
    step(1'b1, 3'b111, '0, av_c, '0, '0);
    step_idle();
    chk("rst_first_gnt", bus.gnt, 3'b001);
    repeat (4) step_idle();

`ifdef ARB_LOCK_EN
    // Lock: requester 0 keeps the port for three grants
    step(1'b0, '0, '0, '0, '0, '0);
    glog_id.delete();
    glog_cyc.delete();
    lkv = 3'b001;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (glog_id.size() >= 3) lkv = '0;
      drive(1'b1, 3'b011, '0, av_c, '0, lkv);
    end
    chk("lock_count", glog_id.size() >= 4, 1'b1);
    if (glog_id.size() >= 4) begin
      chk("lock_g0", glog_id[0], 0);
      chk("lock_g1", glog_id[1], 0);
      chk("lock_g2", glog_id[2], 0);
      chk("lock_g3", glog_id[3], 1);
    end
    repeat (4) step_idle();
`endif

    // Random traffic with occasional resets
    step(1'b0, '0, '0, '0, '0, '0);
    pend = '0; pwe = '0; pav = '0; pdv = '0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (bus.gnt[i]) pend[i] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 35) begin
          pend[i] = 1'b1;
          pwe[i]  = 1'($urandom_range(0, 1));
          pav[i*AW +: AW] = AW'($urandom_range(0, 31));
          pdv[i*DW +: DW] = DW'($urandom);
        end
      end
      rn  = ($urandom_range(0, 399) != 0);
      lkv = N'($urandom);
      drive(rn, pend, pwe, pav, pdv, lkv);
    end
    repeat (4) step_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
